// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcode and funct3 constants, the decode
// bundle layout and the stage FSM state type. The feature macro
// DECODE_ILLEGAL_TRAP_EN selects illegal-opcode trapping in the users.
package decode_stage_pkg;

    // Major opcodes
    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I1 = 7'b0000011;
    localparam logic [6:0] OPC_I2 = 7'b0010011;
    localparam logic [6:0] OPC_S  = 7'b0100011;
    localparam logic [6:0] OPC_B  = 7'b1100011;
    localparam logic [6:0] OPC_J  = 7'b1101111;

    // Memory access sizes carried in funct3
    localparam logic [2:0] F3_LDB = 3'b000;
    localparam logic [2:0] F3_LDW = 3'b010;
    localparam logic [2:0] F3_STB = 3'b000;
    localparam logic [2:0] F3_STW = 3'b010;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    // Everything in the decode bundle except the XLEN-wide immediate and PC
    typedef struct packed {
        logic [13:0] op;
        logic        y_sel;
        logic [4:0]  addr_a;
        logic [4:0]  addr_b;
        logic [4:0]  addr_d;
        logic        read_mmu;
        logic        write_mmu;
        logic        byte_select_mmu;
        logic        write;
        logic        branch_instr;
        logic        load_instr;
        logic        jump_instr;
        logic        illegal;
    } bundle_t;

    localparam int BUNDLE_W = $bits(bundle_t);

endpackage

// File: rtl/decode_stage_decode_logic.sv
// Pure combinational instruction decoder: instruction word -> control
// bundle plus sign-extended immediate. With DECODE_ILLEGAL_TRAP_EN an
// unknown opcode raises the illegal bit; otherwise it decodes as a NOP.
module decode_logic
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] ir,
    output bundle_t         bundle,
    output logic [XLEN-1:0] immed
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    // Decode by major opcode; every field defaults to 0 so nothing is left X
    always_comb begin
        bundle        = '0;
        immed         = '0;
        bundle.addr_a = ir[19:15];
        bundle.addr_b = ir[24:20];
        bundle.addr_d = ir[11:7];
        case (opcode)
            OPC_R: begin
                bundle.op    = {opcode, funct7};
                bundle.y_sel = 1'b1;
                bundle.write = 1'b1;
            end
            OPC_I1: begin
                bundle.op              = {4'b0, opcode, funct3};
                immed                  = {{(XLEN-12){ir[31]}}, ir[31:20]};
                bundle.write           = 1'b1;
                bundle.read_mmu        = 1'b1;
                bundle.load_instr      = 1'b1;
                bundle.byte_select_mmu = (funct3 == F3_LDB);
            end
            OPC_I2: begin
                bundle.op    = {4'b0, opcode, funct3};
                immed        = {{(XLEN-12){ir[31]}}, ir[31:20]};
                bundle.write = 1'b1;
            end
            OPC_S: begin
                bundle.op              = {4'b0, opcode, funct3};
                immed                  = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
                bundle.write_mmu       = 1'b1;
                bundle.byte_select_mmu = (funct3 == F3_STB);
            end
            OPC_B: begin
                // funct3 rides along so the ALU can select the compare
                bundle.op           = {4'b0, opcode, funct3};
                immed               = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
                bundle.y_sel        = 1'b1;
                bundle.branch_instr = 1'b1;
            end
            OPC_J: begin
                bundle.op         = {7'b0, opcode};
                immed             = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
                bundle.write      = 1'b1;
                bundle.jump_instr = 1'b1;
            end
            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                bundle.illegal = 1'b1;
`else
                bundle.illegal = 1'b0;
`endif
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Pipelined decode stage: DEPTH-entry instruction queue feeding a
// registered decode bundle. Optional DECODE_ILLEGAL_TRAP_EN adds a
// RUN/TRAP state that stalls issue after an illegal bundle is consumed.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// A producer holds valid and payload stable until that edge; ready may
// depend combinationally on the consumer's own state but never on valid.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_ir,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [13:0]     op,
    output logic            y_sel,
    output logic [4:0]      addr_a,
    output logic [4:0]      addr_b,
    output logic [4:0]      addr_d,
    output logic [XLEN-1:0] immed,
    output logic            read_mmu,
    output logic            write_mmu,
    output logic            byte_select_mmu,
    output logic            write,
    output logic            branch_instr,
    output logic            load_instr,
    output logic            jump_instr,
    output logic            illegal,
    output state_t          dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] ir_mem [DEPTH];
    logic [XLEN-1:0] pc_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            load;
    logic            consume;
    bundle_t         dec_bundle;
    logic [XLEN-1:0] dec_immed;
    bundle_t         out_bundle;
    logic [XLEN-1:0] out_immed;

    // A full queue refuses input even if it pops this cycle (no push-through)
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full && !flush;
    assign push     = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

`ifdef DECODE_ILLEGAL_TRAP_EN
    state_t state;
    logic   trap_hit;

    assign trap_hit  = consume && out_bundle.illegal;
    assign load      = (state == ST_RUN) && !trap_hit && (!out_valid || out_ready);
    assign dbg_state = state;

    // RUN -> TRAP when an illegal bundle is taken; only flush/reset return
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state <= ST_RUN;
        end else if (trap_hit) begin
            state <= ST_TRAP;
        end
    end
`else
    assign load      = !out_valid || out_ready;
    assign dbg_state = ST_RUN;
`endif

    assign pop = load && !empty;

    decode_logic #(.XLEN(XLEN)) u_decode (
        .ir     (ir_mem[rd_ptr]),
        .bundle (dec_bundle),
        .immed  (dec_immed)
    );

    // Queue storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            ir_mem[wr_ptr] <= in_ir;
            pc_mem[wr_ptr] <= in_pc;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Output register: refill when empty or consumed, otherwise hold
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_bundle <= '0;
            out_immed  <= '0;
            out_pc     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= !empty;
            if (!empty) begin
                out_bundle <= dec_bundle;
                out_immed  <= dec_immed;
                out_pc     <= pc_mem[rd_ptr];
            end
        end
`ifdef DECODE_ILLEGAL_TRAP_EN
        else if (trap_hit) begin
            out_valid <= 1'b0;
        end
`endif
    end

    assign op              = out_bundle.op;
    assign y_sel           = out_bundle.y_sel;
    assign addr_a          = out_bundle.addr_a;
    assign addr_b          = out_bundle.addr_b;
    assign addr_d          = out_bundle.addr_d;
    assign immed           = out_immed;
    assign read_mmu        = out_bundle.read_mmu;
    assign write_mmu       = out_bundle.write_mmu;
    assign byte_select_mmu = out_bundle.byte_select_mmu;
    assign write           = out_bundle.write;
    assign branch_instr    = out_bundle.branch_instr;
    assign load_instr      = out_bundle.load_instr;
    assign jump_instr      = out_bundle.jump_instr;
    assign illegal         = out_bundle.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed decode cases, back-
// pressure, flush, illegal-opcode handling and a randomized phase, all
// scored against a reference decoder built from the instruction rules.
module tb_decode_stage;

    localparam int BW    = 102;
    localparam int DEPTH = 4;
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ir;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [13:0] op;
    logic        y_sel;
    logic [4:0]  addr_a;
    logic [4:0]  addr_b;
    logic [4:0]  addr_d;
    logic [31:0] immed;
    logic        read_mmu;
    logic        write_mmu;
    logic        byte_select_mmu;
    logic        write;
    logic        branch_instr;
    logic        load_instr;
    logic        jump_instr;
    logic        illegal;
    decode_stage_pkg::state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [BW-1:0] exp_q[$];
    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_obs   = '0;
    logic          last_in_ready;
    logic [31:0]   pc_ctr = 32'h0000_1000;

    decode_stage #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_ir           (in_ir),
        .in_pc           (in_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .op              (op),
        .y_sel           (y_sel),
        .addr_a          (addr_a),
        .addr_b          (addr_b),
        .addr_d          (addr_d),
        .immed           (immed),
        .read_mmu        (read_mmu),
        .write_mmu       (write_mmu),
        .byte_select_mmu (byte_select_mmu),
        .write           (write),
        .branch_instr    (branch_instr),
        .load_instr      (load_instr),
        .jump_instr      (jump_instr),
        .illegal         (illegal),
        .dbg_state       (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Two's-complement interpretation of a bits-wide field
    function automatic longint sext(input longint v, input int bits);
        longint half;
        half = longint'(1) << (bits - 1);
        return (v >= half) ? v - (half * 2) : v;
    endfunction

    // Reference decoder: field values computed arithmetically from the ISA rules
    function automatic logic [BW-1:0] ref_bundle(input logic [31:0] ir, input logic [31:0] pc);
        int     opc;
        int     f3;
        int     f7;
        int     opv;
        longint imm;
        logic   ys, rm, wm, bs, wr, br, ld, jp, il;
        logic [13:0] op14;
        logic [31:0] imm32;
        opc = int'(ir[6:0]);
        f3  = int'(ir[14:12]);
        f7  = int'(ir[31:25]);
        opv = 0;
        imm = 0;
        {ys, rm, wm, bs, wr, br, ld, jp, il} = '0;
        case (opc)
            'h33: begin opv = opc * 128 + f7; ys = 1; wr = 1; end
            'h03: begin
                opv = opc * 8 + f3; imm = sext(longint'(ir[31:20]), 12);
                wr = 1; rm = 1; ld = 1; bs = (f3 == 0);
            end
            'h13: begin opv = opc * 8 + f3; imm = sext(longint'(ir[31:20]), 12); wr = 1; end
            'h23: begin
                opv = opc * 8 + f3; imm = sext(longint'(f7 * 32 + int'(ir[11:7])), 12);
                wm = 1; bs = (f3 == 0);
            end
            'h63: begin
                opv = opc * 8 + f3;
                imm = sext(longint'(int'(ir[31]) * 4096 + int'(ir[7]) * 2048
                                    + int'(ir[30:25]) * 32 + int'(ir[11:8]) * 2), 13);
                ys = 1; br = 1;
            end
            'h6F: begin
                opv = opc;
                imm = sext(longint'(int'(ir[31]) * 1048576 + int'(ir[19:12]) * 4096
                                    + int'(ir[20]) * 2048 + int'(ir[30:21]) * 2), 21);
                wr = 1; jp = 1;
            end
            default: il = TRAP_EN;
        endcase
        op14  = opv[13:0];
        imm32 = imm[31:0];
        return {pc, op14, ys, ir[19:15], ir[24:20], ir[11:7], imm32,
                rm, wm, bs, wr, br, ld, jp, il};
    endfunction

    function automatic logic [BW-1:0] obs();
        return {out_pc, op, y_sel, addr_a, addr_b, addr_d, immed,
                read_mmu, write_mmu, byte_select_mmu, write,
                branch_instr, load_instr, jump_instr, illegal};
    endfunction

    // Random instruction; unknown opcodes only when allowed
    function automatic logic [31:0] gen_ir(input bit allow_bad);
        logic [6:0]  tab [7];
        logic [31:0] r;
        int          idx;
        tab = '{7'h33, 7'h03, 7'h13, 7'h23, 7'h63, 7'h6F, 7'h7F};
        r   = $urandom();
        idx = allow_bad ? $urandom_range(0, 6) : $urandom_range(0, 5);
        return {r[31:7], tab[idx]};
    endfunction

    task automatic check(input string tag, input logic [127:0] o, input logic [127:0] e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // One clock: drive, score the handshakes seen this cycle, advance
    task automatic tick(input logic iv, input logic [31:0] ir, input logic [31:0] pc,
                        input logic ordy);
        logic [BW-1:0] e;
        in_valid  = iv;
        in_ir     = ir;
        in_pc     = pc;
        out_ready = ordy;
        #1;
        if (prev_stall) check("hold", {out_valid, obs()}, {1'b1, prev_obs});
        if (out_valid && out_ready) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = 'x;
            check("bundle", obs(), e);
        end
        last_in_ready = in_ready;
        if (in_valid && in_ready) exp_q.push_back(ref_bundle(in_ir, in_pc));
        prev_stall = out_valid && !out_ready && !flush;
        prev_obs   = obs();
        @(posedge clk);
        #1;
    endtask

    // Push one instruction into an idle stage and wait for its bundle
    task automatic push_one(input string tag, input logic [31:0] ir);
        pc_ctr += 4;
        tick(1'b1, ir, pc_ctr, 1'b1);
        check({tag, "_lat0"}, out_valid, 1'b0);
        tick(1'b0, 32'h0, 32'h0, 1'b1);
        check({tag, "_lat1"}, out_valid, 1'b1);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ir = '0; in_pc = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_bundle", obs(), '0);
        check("reset_state", dbg_state, decode_stage_pkg::ST_RUN);

        // Directed decode cases
        push_one("add", 32'h002081B3);
        check("add_fields", {y_sel, write, addr_a, addr_b, addr_d}, {1'b1, 1'b1, 5'd1, 5'd2, 5'd3});
        push_one("addi", 32'hFFF00093);
        check("addi_fields", {immed, y_sel, write}, {32'hFFFFFFFF, 1'b0, 1'b1});
        push_one("lw", 32'h00812283);
        check("lw_fields", {immed, read_mmu, load_instr, byte_select_mmu}, {32'd8, 1'b1, 1'b1, 1'b0});
        push_one("beq", 32'hFE000EE3);
        check("beq_fields", {immed, branch_instr}, {32'hFFFFFFFC, 1'b1});
        push_one("jal", 32'h008000EF);
        check("jal_fields", {immed, jump_instr, write}, {32'd8, 1'b1, 1'b1});
        push_one("sb", 32'h00510023);
        check("sb_fields", {write_mmu, byte_select_mmu, write}, {1'b1, 1'b1, 1'b0});
        tick(1'b0, 32'h0, 32'h0, 1'b1);

        // Back-pressure: 5 instructions fill the output register plus DEPTH entries
        for (int i = 0; i < 5; i++) begin
            pc_ctr += 4;
            tick(1'b1, gen_ir(1'b0), pc_ctr, 1'b0);
        end
        check("bp_accepted", exp_q.size(), 5);
        check("bp_full", in_ready, 1'b0);
        tick(1'b1, gen_ir(1'b0), 32'hDEAD0000, 1'b0);
        tick(1'b1, gen_ir(1'b0), 32'hDEAD0004, 1'b1);
        check("no_push_through", last_in_ready, 1'b0);
        for (int i = 0; i < DEPTH + 4; i++) tick(1'b0, 32'h0, 32'h0, 1'b1);
        check("bp_drained", exp_q.size(), 0);

        // Flush with three queued and a valid bundle held
        for (int i = 0; i < 4; i++) begin
            pc_ctr += 4;
            tick(1'b1, gen_ir(1'b0), pc_ctr, 1'b0);
        end
        check("pre_flush_valid", out_valid, 1'b1);
        flush = 1'b1;
        tick(1'b1, 32'h002081B3, 32'hBEEF0000, 1'b0);
        check("flush_refuse", last_in_ready, 1'b0);
        flush = 1'b0;
        exp_q.delete();
        check("flush_out_valid", out_valid, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 32'h0, 1'b1);
        check("flush_queue_empty", out_valid, 1'b0);

        // Unknown opcode followed by ADD
        pc_ctr += 4;
        tick(1'b1, 32'hFFFFFFFF, pc_ctr, 1'b1);
        pc_ctr += 4;
        tick(1'b1, 32'h002081B3, pc_ctr, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 32'h0, 32'h0, 1'b1);
`ifdef DECODE_ILLEGAL_TRAP_EN
        check("trap_withheld", out_valid, 1'b0);
        check("trap_pending", exp_q.size(), 1);
        check("trap_state", dbg_state, decode_stage_pkg::ST_TRAP);
        flush = 1'b1;
        tick(1'b0, 32'h0, 32'h0, 1'b1);
        flush = 1'b0;
        exp_q.delete();
        check("trap_cleared", dbg_state, decode_stage_pkg::ST_RUN);
        push_one("post_trap_add", 32'h002081B3);
        tick(1'b0, 32'h0, 32'h0, 1'b1);
`endif
        check("nop_then_add", exp_q.size(), 0);

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            flush = ($urandom_range(0, 49) == 0);
            pc_ctr += 4;
            tick($urandom_range(0, 9) < 7, gen_ir(!TRAP_EN), pc_ctr, $urandom_range(0, 9) < 6);
            if (flush) begin
                exp_q.delete();
                flush = 1'b0;
            end
        end
        flush = 1'b0;
        for (int i = 0; i < DEPTH + 4; i++) tick(1'b0, 32'h0, 32'h0, 1'b1);
        check("final_drained", exp_q.size(), 0);
        check("final_idle", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
